// File: rtl/xdefs.sv
// Shared definitions for the display/switch controller: widths, data-bus
// address map, sequencer step encoding and the 7-segment glyph table.
package xdefs;

  localparam int DATA_W      = 32;
  localparam int REGF_ADDR_W = 4;
  localparam int ADDR_W      = 6;

  // Data-bus address map
  localparam logic [ADDR_W-1:0] A_R0   = 6'h00;
  localparam logic [ADDR_W-1:0] A_R1   = 6'h01;
  localparam logic [ADDR_W-1:0] A_SW   = 6'h10;
  localparam logic [ADDR_W-1:0] A_BTN  = 6'h11;
  localparam logic [ADDR_W-1:0] A_LED  = 6'h12;
  localparam logic [ADDR_W-1:0] A_DISP = 6'h13;

  // Register that free-runs as a step counter, and the one used as the
  // display-update condition
  localparam int INC_REG  = 2;
  localparam int COND_REG = 1;

  typedef enum logic [1:0] {
    PC_SW   = 2'd0,
    PC_BTN  = 2'd1,
    PC_LED  = 2'd2,
    PC_DISP = 2'd3
  } pc_t;

  typedef enum logic [2:0] {
    REG_REGF,
    REG_SW,
    REG_BTN,
    REG_LED,
    REG_DISP,
    REG_EXT,
    REG_NONE
  } region_t;

  // Classify a data-bus address into the region that answers it
  function automatic region_t decode(input logic [ADDR_W-1:0] a);
    region_t r;
    r = REG_NONE;
    if (a[5:4] == 2'b00)  r = REG_REGF;
    else if (a == A_SW)   r = REG_SW;
    else if (a == A_BTN)  r = REG_BTN;
    else if (a == A_LED)  r = REG_LED;
    else if (a == A_DISP) r = REG_DISP;
`ifdef EXT_BASE
    else if (a[5])        r = REG_EXT;
`endif
    return r;
  endfunction

  // Active-low segment pattern, bit0=a .. bit6=g, bit7=dp held off
  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/xdisp.sv
// 4-digit multiplexed 7-segment driver. Segment and select outputs are
// registered together so a digit never shows its neighbour's pattern.
module xdisp
  import xdefs::*;
#(
  parameter int DISP_DIV = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  output logic [7:0]  seg,
  output logic [3:0]  sel
);

  localparam int CW = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic [1:0]    digit;
  logic [1:0]    digit_next;
  logic          tick;
  logic [3:0]    nib;

  assign tick       = (div_cnt == CW'(DISP_DIV - 1));
  assign digit_next = tick ? digit + 2'd1 : digit;

  // Nibble belonging to the digit that will be lit after this edge
  always_comb begin
    nib = value[3:0];
    case (digit_next)
      2'd0: nib = value[3:0];
      2'd1: nib = value[7:4];
      2'd2: nib = value[11:8];
      default: nib = value[15:12];
    endcase
  end

  // Slot timer, digit rotation and registered pin drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      digit   <= 2'd0;
      sel     <= 4'b1110;
      seg     <= 8'hC0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + CW'(1);
      digit   <= digit_next;
      sel     <= ~(4'b0001 << digit_next);
      seg     <= seg7(nib);
    end
  end

endmodule

// File: rtl/xregf.sv
// 16 x DATA_W register file: two combinational read ports, one write port,
// and a dedicated increment path for the step-counter register.
module xregf
  import xdefs::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REGF_ADDR_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0]      rd_a_data,
  input  logic [REGF_ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0]      rd_b_data,
  input  logic                   wr_en,
  input  logic [REGF_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   inc_en
);

  localparam int NREG = 1 << REGF_ADDR_W;

  logic [DATA_W-1:0] regf [0:NREG-1];

  assign rd_a_data = regf[rd_a_addr];
  assign rd_b_data = regf[rd_b_addr];

  // Bus write has priority over the counter increment on the same register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regf[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_en && wr_addr == REGF_ADDR_W'(i))
          regf[i] <= wr_data;
        else if (inc_en && i == INC_REG)
          regf[i] <= regf[i] + DATA_W'(1);
      end
    end
  end

endmodule

// File: rtl/xtop.sv
// Board top: input synchronisers, fixed 4-step sequencer over an internal
// data bus, address decode with sticky trap, LED and display registers.
module xtop
  import xdefs::*;
#(
  parameter int DISP_DIV = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Btn3,
  input  logic [7:0]        Sw,
  output logic [7:0]        Led,
  output logic [7:0]        Disp,
  output logic [3:0]        Disp_sel,
  output logic              trap
`ifdef EXT_BASE
  ,
  output logic [ADDR_W-2:0] par_addr,
  output logic              par_we,
  input  logic [DATA_W-1:0] par_in,
  output logic [DATA_W-1:0] par_out
`endif
);

  logic [7:0]        sw_s1, sw_s2;
  logic              btn_s1, btn_s2;
  pc_t               pc;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] data_addr;
  logic              step_we;
  logic              inc_step;
  logic              data_we;
  logic              inc_en;
  logic              illegal;
  region_t           src_region;
  region_t           dst_region;
  logic [DATA_W-1:0] regf_rd_data;
  logic [DATA_W-1:0] cond_data;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] wr_data;
  logic [15:0]       disp_val;

  // Two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      sw_s1  <= Sw;
      sw_s2  <= sw_s1;
      btn_s1 <= Btn3;
      btn_s2 <= btn_s1;
    end
  end

  // Fixed program: source address, destination address and write enable per step
  always_comb begin
    src_addr  = A_SW;
    data_addr = A_R0;
    step_we   = 1'b0;
    inc_step  = 1'b0;
    case (pc)
      PC_SW: begin
        src_addr  = A_SW;
        data_addr = A_R0;
        step_we   = 1'b1;
      end
      PC_BTN: begin
        src_addr  = A_BTN;
        data_addr = A_R1;
        step_we   = 1'b1;
      end
      PC_LED: begin
        src_addr  = A_R0;
        data_addr = A_LED;
        step_we   = 1'b1;
        inc_step  = 1'b1;
      end
      default: begin
        src_addr  = A_R0;
        data_addr = A_DISP;
        step_we   = (cond_data == DATA_W'(1));
      end
    endcase
  end

  assign src_region = decode(src_addr);
  assign dst_region = decode(data_addr);

  // Any unmapped access stops the machine; writes are suppressed in reset and after a trap
  assign illegal = ~trap & ((src_region == REG_NONE) | (step_we & (dst_region == REG_NONE)));
  assign data_we = rst & ~trap & ~illegal & step_we;
  assign inc_en  = rst & ~trap & ~illegal & inc_step;

  // Read-data mux selected by the source region
  always_comb begin
    rd_data = '0;
    case (src_region)
      REG_REGF: rd_data = regf_rd_data;
      REG_SW:   rd_data = {{(DATA_W-8){1'b0}}, sw_s2};
      REG_BTN:  rd_data = {{(DATA_W-1){1'b0}}, btn_s2};
      REG_LED:  rd_data = {{(DATA_W-8){1'b0}}, Led};
      REG_DISP: rd_data = {{(DATA_W-16){1'b0}}, disp_val};
`ifdef EXT_BASE
      REG_EXT:  rd_data = par_in;
`endif
      default:  rd_data = '0;
    endcase
  end

  assign wr_data = rd_data;

  xregf regf (
    .clk       (clk),
    .rst       (rst),
    .rd_a_addr (src_addr[REGF_ADDR_W-1:0]),
    .rd_a_data (regf_rd_data),
    .rd_b_addr (REGF_ADDR_W'(COND_REG)),
    .rd_b_data (cond_data),
    .wr_en     (data_we && dst_region == REG_REGF),
    .wr_addr   (data_addr[REGF_ADDR_W-1:0]),
    .wr_data   (wr_data),
    .inc_en    (inc_en)
  );

  // Sequencer state, peripheral registers and the sticky trap flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= PC_SW;
      Led      <= '0;
      disp_val <= '0;
      trap     <= 1'b0;
    end else begin
      if (illegal)
        trap <= 1'b1;
      if (!trap && !illegal)
        pc <= pc_t'(pc + 2'd1);
      if (data_we && dst_region == REG_LED)
        Led <= wr_data[7:0];
      if (data_we && dst_region == REG_DISP)
        disp_val <= wr_data[15:0];
    end
  end

`ifdef EXT_BASE
  assign par_addr = (step_we && dst_region == REG_EXT) ? data_addr[ADDR_W-2:0]
                                                       : src_addr[ADDR_W-2:0];
  assign par_we   = data_we && dst_region == REG_EXT;
  assign par_out  = wr_data;
`endif

  xdisp #(.DISP_DIV(DISP_DIV)) disp_mux (
    .clk   (clk),
    .rst   (rst),
    .value (disp_val),
    .seg   (Disp),
    .sel   (Disp_sel)
  );

endmodule

// File: tb/tb_xtop.sv
// Scoreboard bench for xtop: stimulus queues expected observations with a
// due cycle and a deadline; a negedge monitor pops and compares them.
module tb_xtop;

  localparam int K_LED  = 0;
  localparam int K_SEL  = 1;
  localparam int K_DISP = 2;
  localparam int K_TRAP = 3;
  localparam int K_PC   = 4;
  localparam int K_R0   = 5;
  localparam int K_R1   = 6;
  localparam int K_R2   = 7;
  localparam int K_DIG  = 8;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    int          due;
    int          dl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [7:0] sw;
  logic [7:0] led;
  logic [7:0] disp;
  logic [3:0] disp_sel;
  logic       trap;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  bit          mon_go;
  logic [31:0] mon_act;
  logic [3:0]  sel_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  xtop #(.DISP_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .Btn3     (btn),
    .Sw       (sw),
    .Led      (led),
    .Disp     (disp),
    .Disp_sel (disp_sel),
    .trap     (trap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_LED:   return "led";
      K_SEL:   return "disp_sel";
      K_DISP:  return "disp";
      K_TRAP:  return "trap";
      K_PC:    return "pc";
      K_R0:    return "regf0";
      K_R1:    return "regf1";
      K_R2:    return "regf2";
      default: return "digit";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_LED:   return {24'b0, led};
      K_SEL:   return {28'b0, disp_sel};
      K_DISP:  return {24'b0, disp};
      K_TRAP:  return {31'b0, trap};
      K_PC:    return {30'b0, dut.pc};
      K_R0:    return dut.regf.regf[0];
      K_R1:    return dut.regf.regf[1];
      K_R2:    return dut.regf.regf[2];
      default: return {20'b0, disp_sel, disp};
    endcase
  endfunction

  task automatic push(input int kind, input logic [31:0] exp, input int due, input int dl);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.due  = due;
    e.dl   = dl;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      $display("FAIL drain_timeout pending=%0d required=0 cyc=%0d", sb.size(), cyc);
      n_total += sb.size();
      sb.delete();
    end
  endtask

  // Monitor: compare the head entry once it is due; fail it only at its deadline
  always @(negedge clk) begin
    mon_go = 1'b1;
    while (mon_go && sb.size() > 0) begin
      if (sb[0].due > cyc) begin
        mon_go = 1'b0;
      end else begin
        mon_act = actual(sb[0].kind);
        if (mon_act == sb[0].exp) begin
          n_pass++;
          n_total++;
          $display("ok   %s act=%h exp=%h cyc=%0d", kname(sb[0].kind), mon_act, sb[0].exp, cyc);
          void'(sb.pop_front());
        end else if (cyc >= sb[0].dl) begin
          n_total++;
          $display("FAIL %s act=%h exp=%h cyc=%0d", kname(sb[0].kind), mon_act, sb[0].exp, cyc);
          void'(sb.pop_front());
        end else begin
          mon_go = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c, rel, t, x, r, j;

    // Reset held with Sw=10, Btn3=1
    rst = 1'b0;
    sw  = 8'd10;
    btn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    c = cyc;
    push(K_LED,  32'h00,  c, c);
    push(K_DISP, 32'hC0,  c, c);
    push(K_SEL,  32'hE,   c, c);
    push(K_TRAP, 32'h0,   c, c);
    push(K_PC,   32'h0,   c, c);
    push(K_R0,   32'h0,   c, c);
    drain(10);

    // Release: LED and regf0 follow Sw, display shows 000A
    @(posedge clk);
    #1;
    rst = 1'b1;
    rel = cyc;
    push(K_LED, 32'h0A, rel, rel + 9);
    push(K_R0,  32'd10, rel, rel + 9);
    push(K_DIG, {20'b0, 4'b1110, 8'h88}, rel, rel + 40);
    push(K_DIG, {20'b0, 4'b1101, 8'hC0}, rel, rel + 40);
    push(K_DIG, {20'b0, 4'b1011, 8'hC0}, rel, rel + 40);
    push(K_DIG, {20'b0, 4'b0111, 8'hC0}, rel, rel + 40);
    drain(100);

    // Sw 10 -> 11
    @(posedge clk);
    #1;
    sw = 8'd11;
    t = cyc;
    push(K_LED, 32'h0B, t, t + 8);
    push(K_DIG, {20'b0, 4'b1110, 8'h83}, t, t + 30);
    drain(100);

    // Btn3 low freezes the display value while LED keeps tracking
    @(posedge clk);
    #1;
    btn = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    sw = 8'h5F;
    t = cyc;
    push(K_LED, 32'h5F, t, t + 8);
    drain(100);
    @(posedge clk);
    #1;
    x = cyc;
    push(K_DIG, {20'b0, 4'b1110, 8'h83}, x, x + 20);
    push(K_DIG, {20'b0, 4'b1101, 8'hC0}, x, x + 20);
    drain(100);

    // Btn3 high: display catches up to 005F
    @(posedge clk);
    #1;
    btn = 1'b1;
    t = cyc;
    push(K_DIG, {20'b0, 4'b1110, 8'h8E}, t, t + 30);
    push(K_DIG, {20'b0, 4'b1101, 8'h92}, t, t + 40);
    push(K_DIG, {20'b0, 4'b1011, 8'hC0}, t, t + 40);
    push(K_DIG, {20'b0, 4'b0111, 8'hC0}, t, t + 40);
    drain(100);

    // Free run: pc phase and step counter follow the cycle count since release
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      c = cyc;
      j = c - rel;
      push(K_PC, 32'(j % 4), c, c);
      push(K_R2, 32'((j + 1) / 4), c, c);
      if (i == 0) begin
        push(K_R1,   32'd1, c, c);
        push(K_TRAP, 32'd0, c, c);
      end
      drain(10);
    end

    // Reset mid-loop: outputs return to reset values at once
    @(posedge clk);
    #2;
    rst = 1'b0;
    c = cyc;
    push(K_LED,  32'h00, c, c);
    push(K_SEL,  32'hE,  c, c);
    push(K_DISP, 32'hC0, c, c);
    push(K_TRAP, 32'h0,  c, c);
    push(K_PC,   32'h0,  c, c);
    push(K_R2,   32'h0,  c, c);
    drain(10);
    repeat (3) @(posedge clk);

    // Release: digit select rotates every 4 cycles, LED recovers within 8
    @(posedge clk);
    #1;
    rst = 1'b1;
    r = cyc;
    for (int k = 0; k < 20; k++) begin
      push(K_SEL, {28'b0, sel_tab[(k / 4) % 4]}, r + k, r + k);
      if (k == 8) push(K_LED, 32'h5F, r + 8, r + 8);
    end
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
